// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM states,
// parity modes and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_len(input int data_bits, input int parity,
                                     input int stop_bits, input int clks_per_bit);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible on dout while not empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;

    // Storage needs no reset: its contents are only trusted below the level count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;
    assign full  = (level_r == LW'(DEPTH));
    assign empty = (level_r == LW'(0));

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with elaboration-time frame format and an internal transmit
// FIFO; frames leave back-to-back while words are queued.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_BITS-1:0]              s_data,
    output logic                              tx_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH+1);

    if (CLKS_PER_BIT < 2) begin : g_err_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_err_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e               state_r, state_nxt_s;
    logic [TW-1:0]           timer_r, timer_nxt_s;
    logic [3:0]              bit_r, bit_nxt_s;
    logic [DATA_BITS-1:0]    shift_r, shift_nxt_s;
    logic                    par_r, par_nxt_s;
    logic                    tx_r, tx_cur_s;
    logic                    busy_r;
    logic                    ready_r, ready_nxt_s;
    logic                    push_s, pop_s, tim_last_s;
    logic [DATA_BITS-1:0]    fifo_dout_s;
    logic [LW-1:0]           fifo_level_s;
    logic                    fifo_full_s, fifo_empty_s;

    assign push_s     = s_valid && ready_r;
    assign tim_last_s = (timer_r == TW'(CLKS_PER_BIT - 1));

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .din    (s_data),
        .pop    (pop_s),
        .dout   (fifo_dout_s),
        .level  (fifo_level_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Ready for next cycle is the occupancy after this cycle's push/pop being below depth.
    always_comb begin
        ready_nxt_s = 1'b0;
        if (pop_s) begin
            ready_nxt_s = 1'b1;
        end else if (push_s) begin
            ready_nxt_s = (fifo_level_s != LW'(FIFO_DEPTH - 1));
        end else begin
            ready_nxt_s = !fifo_full_s;
        end
    end

    // Next-state logic; tx_cur_s is the line level for the current state, registered below.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = tim_last_s ? TW'(0) : timer_r + TW'(1);
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        pop_s       = 1'b0;
        tx_cur_s    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = TW'(0);
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_dout_s;
                    par_nxt_s   = ^fifo_dout_s;
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_cur_s = 1'b0;
                if (tim_last_s) begin
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                tx_cur_s = shift_r[0];
                if (tim_last_s) begin
                    shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_r == 4'(DATA_BITS - 1)) begin
                        bit_nxt_s   = 4'd0;
                        state_nxt_s = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_nxt_s   = bit_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                tx_cur_s = (PARITY == PAR_ODD) ? ~par_r : par_r;
                if (tim_last_s) begin
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_cur_s = 1'b1;
                if (tim_last_s && bit_r == 4'(STOP_BITS - 1)) begin
                    bit_nxt_s = 4'd0;
                    if (!fifo_empty_s) begin
                        // Chain straight into the next start bit, no idle cell.
                        pop_s       = 1'b1;
                        shift_nxt_s = fifo_dout_s;
                        par_nxt_s   = ^fifo_dout_s;
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (tim_last_s) begin
                    bit_nxt_s = bit_r + 4'd1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = TW'(0);
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            timer_r <= TW'(0);
            bit_r   <= 4'd0;
            shift_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            par_r   <= par_nxt_s;
            tx_r    <= tx_cur_s;
            busy_r  <= (state_r != ST_IDLE) || (fifo_level_s != LW'(0));
            ready_r <= ready_nxt_s;
        end
    end

    assign tx_o    = tx_r;
    assign busy_o  = busy_r;
    assign s_ready = ready_r;
    assign level_o = fifo_level_s;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Self-checking bench: four frame formats side by side, a table of single
// frames plus hand sequences for FIFO back-to-back, full and reset corners.
module tb_uart_tx_fifo_cfg;
    import uart_pkg::*;

    localparam int CPB = 4;

    typedef struct {
        logic [11:0] cells;
        int          n;
    } frame_t;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [11:0] cells;
        int          n;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [1:0] sel = 2'd0;
    logic [3:0] tx_w, busy_w, ready_w;
    logic [2:0] lvl0, lvl1, lvl2, lvl3;
    logic       tx_mon, busy_mon, ready_mon;
    logic [2:0] lvl_mon;

    int     total = 0;
    int     bad = 0;
    frame_t sb_q[$];
    vec_t   vecs[9];

    always #5 clk = ~clk;

    uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid && (sel == 2'd0)), .s_ready(ready_w[0]),
        .s_data(s_data), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .level_o(lvl0));
    uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid && (sel == 2'd1)), .s_ready(ready_w[1]),
        .s_data(s_data), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .level_o(lvl1));
    uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid && (sel == 2'd2)), .s_ready(ready_w[2]),
        .s_data(s_data), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .level_o(lvl2));
    uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .clk(clk), .resetn(resetn), .s_valid(s_valid && (sel == 2'd3)), .s_ready(ready_w[3]),
        .s_data(s_data[6:0]), .tx_o(tx_w[3]), .busy_o(busy_w[3]), .level_o(lvl3));

    assign tx_mon    = tx_w[sel];
    assign busy_mon  = busy_w[sel];
    assign ready_mon = ready_w[sel];
    assign lvl_mon   = (sel == 2'd0) ? lvl0 : (sel == 2'd1) ? lvl1 : (sel == 2'd2) ? lvl2 : lvl3;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_t f8n1(input logic [7:0] d);
        frame_t f;
        f.cells = {2'b00, 1'b1, d, 1'b0};
        f.n     = 10;
        return f;
    endfunction

    function automatic int cfg_len(input logic [1:0] s);
        case (s)
            2'd0:    return frame_len(8, PAR_NONE, 1, CPB);
            2'd1:    return frame_len(8, PAR_EVEN, 1, CPB);
            2'd2:    return frame_len(8, PAR_ODD, 1, CPB);
            default: return frame_len(7, PAR_EVEN, 2, CPB);
        endcase
    endfunction

    // Call at a negedge; returns at the negedge right after the pushing edge.
    task automatic push_word(input logic [7:0] d, input frame_t f);
        int w = 0;
        while (!ready_mon && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", int'(ready_mon), 1);
        s_valid = 1'b1;
        s_data  = d;
        sb_q.push_back(f);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int m = 0;
        while (busy_mon && m < 2000) begin
            @(negedge clk);
            m++;
        end
        check(name, int'(busy_mon), 0);
    endtask

    task automatic run_vec(input vec_t v);
        frame_t fr;
        int k = 0;
        int m = 0;
        sel = v.sel;
        @(negedge clk);
        fr.cells = v.cells;
        fr.n     = v.n;
        push_word(v.data, fr);
        check("level_after_push", int'(lvl_mon), 1);
        while (tx_mon && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("start_latency", k, 2);
        while (busy_mon && m < 500) begin
            @(negedge clk);
            m++;
        end
        check("busy_cycles", m, cfg_len(v.sel));
    endtask

    // Scoreboard monitor: every start bit pops one expected frame; each cell checked every cycle.
    initial begin
        frame_t f;
        bit     abort;
        bit     ok;
        logic   act;
        forever begin
            @(negedge tx_mon);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: start bit at t=%0t, expected no frame", $time);
            end else begin
                f     = sb_q[0];
                abort = 1'b0;
                for (int i = 0; i < f.n && !abort; i++) begin
                    ok  = 1'b1;
                    act = 1'b0;
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (!resetn) begin
                            abort = 1'b1;
                        end else if (ok) begin
                            act = tx_mon;
                            if (tx_mon !== f.cells[i]) ok = 1'b0;
                        end
                    end
                    if (!abort) check($sformatf("frame_cell%0d", i), int'(act), int'(f.cells[i]));
                end
                if (!abort) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_tx, n_busy, n_rdy, k, waited, lvlbad, m;
        logic [7:0] wb [6];

        vecs[0] = '{2'd0, 8'hA5, 12'b00_1_10100101_0, 10};
        vecs[1] = '{2'd1, 8'hA5, 12'b0_1_0_10100101_0, 11};
        vecs[2] = '{2'd2, 8'hA5, 12'b0_1_1_10100101_0, 11};
        vecs[3] = '{2'd3, 8'h07, 12'b0_11_1_0000111_0, 11};
        vecs[4] = '{2'd0, 8'h00, 12'b00_1_00000000_0, 10};
        vecs[5] = '{2'd0, 8'hFF, 12'b00_1_11111111_0, 10};
        vecs[6] = '{2'd1, 8'h01, 12'b0_1_1_00000001_0, 11};
        vecs[7] = '{2'd2, 8'h00, 12'b0_1_1_00000000_0, 11};
        vecs[8] = '{2'd3, 8'h7F, 12'b0_11_1_1111111_0, 11};

        // Reset values and release.
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx_mon), 1);
        check("rst_busy", int'(busy_mon), 0);
        check("rst_ready", int'(ready_mon), 0);
        check("rst_level", int'(lvl_mon), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(ready_mon), 1);

        // Idle line for 100 cycles.
        n_tx = 0; n_busy = 0; n_rdy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_mon === 1'b1) n_tx++;
            if (busy_mon === 1'b0) n_busy++;
            if (ready_mon === 1'b1) n_rdy++;
        end
        check("idle_tx_high", n_tx, 100);
        check("idle_busy_low", n_busy, 100);
        check("idle_ready_high", n_rdy, 100);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Four back-to-back words, then a push on the very edge of the STOP->START pop.
        sel = 2'd0;
        @(negedge clk);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("a_ready", int'(ready_mon), 1);
            s_data = 8'h31 + 8'(i);
            sb_q.push_back(f8n1(8'h31 + 8'(i)));
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (37) @(negedge clk);
        check("a_level_before", int'(lvl_mon), 3);
        s_valid = 1'b1;
        s_data  = 8'h35;
        sb_q.push_back(f8n1(8'h35));
        @(negedge clk);
        s_valid = 1'b0;
        check("a_level_same_edge", int'(lvl_mon), 3);
        m = 0;
        while (busy_mon && m < 1000) begin
            @(negedge clk);
            m++;
        end
        check("a_back_to_back_cycles", m, 5 * cfg_len(2'd0) - 39);

        // Six words with s_valid held high: the producer must stall while full.
        for (int i = 0; i < 6; i++) wb[i] = 8'h41 + 8'(i);
        k = 0; waited = 0; lvlbad = 0; m = 0;
        s_valid = 1'b1;
        while (k < 6 && m < 400) begin
            s_data = wb[k];
            if (ready_mon) begin
                sb_q.push_back(f8n1(wb[k]));
                k++;
            end else begin
                waited++;
                if (lvl_mon != 3'd4) lvlbad++;
            end
            @(negedge clk);
            m++;
        end
        s_valid = 1'b0;
        check("b_all_pushed", k, 6);
        check("b_ready_low_seen", int'(waited > 0), 1);
        check("b_blocked_only_when_full", lvlbad, 0);
        wait_idle("b_idle_reached");
        check("b_scoreboard_empty", sb_q.size(), 0);

        // Reset in the middle of the DATA cells of 0x3C with two words queued.
        @(negedge clk);
        s_valid = 1'b1;
        s_data = 8'h3C; sb_q.push_back(f8n1(8'h3C)); @(negedge clk);
        s_data = 8'h11; sb_q.push_back(f8n1(8'h11)); @(negedge clk);
        s_data = 8'h22; sb_q.push_back(f8n1(8'h22)); @(negedge clk);
        s_valid = 1'b0;
        check("c_level_queued", int'(lvl_mon), 2);
        repeat (10) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("c_rst_tx", int'(tx_mon), 1);
        check("c_rst_level", int'(lvl_mon), 0);
        check("c_rst_busy", int'(busy_mon), 0);
        check("c_rst_ready", int'(ready_mon), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("c_ready_after_release", int'(ready_mon), 1);
        n_tx = 0; n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_mon === 1'b1) n_tx++;
            if (busy_mon === 1'b0) n_busy++;
        end
        check("c_no_residual_tx", n_tx, 100);
        check("c_no_residual_busy", n_busy, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
